// File: rtl/mul_div_unit.sv
// mul_div_unit: sequential signed WIDTH x WIDTH multiply / divide engine.
//   Multiply: radix-2 Booth, exact 2*WIDTH-bit two's-complement product.
//   Divide:   non-restoring on operand magnitudes, signs fixed up afterwards
//             (truncation toward zero, remainder carries the dividend's sign).
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-high reset
//   start        request, sampled only while idle
//   op           0 = signed multiply, 1 = signed divide
//   a            multiplicand / dividend
//   b            multiplier / divisor
//   busy         high whenever the engine is not idle
//   done         one-cycle pulse, result valid
//   result       mul: {product_hi, product_lo}; div: {remainder, quotient}
//   div_by_zero  valid with done; divide with b = 0
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t             state_q;
  logic               op_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic [CW-1:0]      cnt_q;
  // Booth: acc/q/qm1 form the shifting {A, Q, Q-1} triple, m_q holds the
  // multiplicand. Divide: acc is the partial remainder, q the dividend
  // shifting out while quotient bits shift in, m_q the divisor magnitude.
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   q_q;
  logic               qm1_q;
  logic [WIDTH-1:0]   m_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;
  logic               dbz_q;

  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   q_d;
  logic               qm1_d;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH:0]     div_shift;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     rem_fix;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [2*WIDTH-1:0] fin_d;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
  // is representable as an unsigned WIDTH-bit number.
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
  end

  // One iteration of the selected algorithm.
  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    step_sum  = acc_q;
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    if (!op_q) begin
      case ({q_q[0], qm1_q})
        2'b01:   step_sum = acc_q + {m_q[WIDTH-1], m_q};
        2'b10:   step_sum = acc_q - {m_q[WIDTH-1], m_q};
        default: step_sum = acc_q;
      endcase
      acc_d = {step_sum[WIDTH], step_sum[WIDTH:1]};
      q_d   = {step_sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
    end else begin
      // The partial remainder stays within [-D, D), so its top two bits are
      // equal and dropping acc_q[WIDTH] in the shift loses nothing.
      if (acc_q[WIDTH]) begin
        step_sum = div_shift + {1'b0, m_q};
      end else begin
        step_sum = div_shift - {1'b0, m_q};
      end
      acc_d = step_sum;
      q_d   = {q_q[WIDTH-2:0], ~step_sum[WIDTH]};
      qm1_d = 1'b0;
    end
  end

  // Finalization applied on the FIX edge.
  always_comb begin
    rem_fix = acc_q[WIDTH] ? (acc_q + {1'b0, m_q}) : acc_q;
    quo_s   = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
    rem_s   = a_neg_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
    if (op_q) begin
      fin_d = {rem_s, quo_s};
    end else begin
      fin_d = {acc_q[WIDTH-1:0], q_q};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            a_neg_q <= a[WIDTH-1];
            b_neg_q <= b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            if (op && (b == '0)) begin
              result_q <= {a, {WIDTH{1'b1}}};
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= RUN;
              if (op) begin
                q_q <= a_mag;
                m_q <= b_mag;
              end else begin
                q_q <= b;
                m_q <= a;
              end
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fin_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven checks of mul_div_unit with a scoreboard
// queue; expected values come from constants and a behavioural model built
// on 64-bit signed arithmetic.
module tb_mul_div_unit;

  localparam int unsigned W       = 32;
  localparam int unsigned LAT_RUN = W + 2;
  localparam int unsigned TIMEOUT = 200;

  logic            clock;
  logic            clear;
  logic            start;
  logic            op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  result;
  logic            div_by_zero;

  typedef struct {
    string         name;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] res;
    logic          dbz;
    int unsigned   lat;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic mop,
                                           input logic [W-1:0] ma,
                                           input logic [W-1:0] mb);
    longint sa;
    longint sb;
    longint p;
    logic [63:0] qv;
    logic [63:0] rv;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (!mop) begin
      p = sa * sb;
      return p;
    end
    if (mb == '0) return {ma, {W{1'b1}}};
    qv = sa / sb;
    rv = sa % sb;
    return {rv[W-1:0], qv[W-1:0]};
  endfunction

  function automatic vec_t mkvec(input string name, input logic vop,
                                 input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic [2*W-1:0] vres);
    vec_t v;
    v.name = name;
    v.op   = vop;
    v.a    = va;
    v.b    = vb;
    v.res  = vres;
    v.dbz  = vop && (vb == '0);
    v.lat  = v.dbz ? 1 : LAT_RUN;
    return v;
  endfunction

  // Drive one operation, push its expectation, wait for done, pop and check.
  // inject_at > 0 pulses a stray start (with other operands) at that cycle;
  // start_in_done asserts start during the done cycle, which must be ignored.
  task automatic run_op(input vec_t v, input int unsigned inject_at,
                        input bit start_in_done);
    int unsigned lat;
    vec_t e;
    @(negedge clock);
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    exp_q.push_back(v);
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    start = 1'b0;
    op    = $urandom_range(0, 1);
    a     = $urandom;
    b     = $urandom;
    chk({v.name, "_busy_rise"}, {63'd0, busy}, 64'd1);
    if (!v.dbz) chk({v.name, "_dbz_cleared"}, {63'd0, div_by_zero}, 64'd0);
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (inject_at != 0 && lat == inject_at) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    start = 1'b0;
    chk({v.name, "_done_seen"}, {63'd0, done}, 64'd1);
    if (exp_q.size() == 0) begin
      chk({v.name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, "_latency"}, 64'(lat), 64'(e.lat));
      chk({e.name, "_result"}, result, e.res);
      chk({e.name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
      chk({e.name, "_busy_in_done"}, {63'd0, busy}, 64'd1);
      if (start_in_done) begin
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd9;
        b     = 32'd9;
      end
      @(negedge clock);
      start = 1'b0;
      chk({e.name, "_busy_after"}, {63'd0, busy}, 64'd0);
      chk({e.name, "_done_pulse"}, {63'd0, done}, 64'd0);
      chk({e.name, "_result_hold"}, result, e.res);
      if (start_in_done) begin
        @(negedge clock);
        chk({e.name, "_start_in_done_ignored"}, {63'd0, busy}, 64'd0);
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;

    clear = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;

    vecs.push_back(mkvec("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB));
    vecs.push_back(mkvec("mul_minsq", 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000));
    vecs.push_back(mkvec("mul_m1_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001));
    vecs.push_back(mkvec("mul_zero", 1'b0, 32'h12345678, 32'd0, 64'd0));
    vecs.push_back(mkvec("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD));
    vecs.push_back(mkvec("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2));
    vecs.push_back(mkvec("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000));
    vecs.push_back(mkvec("div_small", 1'b1, 32'd3, 32'd10, 64'h00000003_00000000));
    vecs.push_back(mkvec("div_by_0", 1'b1, 32'd5, 32'd0, 64'h00000005_FFFFFFFF));
    vecs.push_back(mkvec("mul_after_dbz", 1'b0, 32'd6, 32'd5, 64'd30));
    vecs.push_back(mkvec("div_min_by_min", 1'b1, 32'h80000000, 32'h80000000, 64'h00000000_00000001));
    for (int unsigned i = 0; i < 10; i++) begin
      rop = i[0];
      ra  = $urandom;
      rb  = (i == 7) ? 32'd3 : $urandom;
      vecs.push_back(mkvec($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb)));
    end

    repeat (2) @(negedge clock);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    clear = 1'b0;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], 0, 1'b0);
    end

    // Stray start at cycle 5 and a start during the done cycle are ignored.
    run_op(mkvec("mul_ignore_start", 1'b0, 32'd6, 32'd7, 64'd42), 5, 1'b1);

    // Asynchronous clear in the middle of a multiply.
    @(negedge clock);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'h1234;
    b     = 32'h10;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    chk("pre_clear_busy", {63'd0, busy}, 64'd1);
    #2 clear = 1'b1;
    #1;
    chk("clear_busy", {63'd0, busy}, 64'd0);
    chk("clear_done", {63'd0, done}, 64'd0);
    chk("clear_result", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (2) @(negedge clock);
    chk("clear_stays_idle", {63'd0, busy}, 64'd0);

    run_op(mkvec("mul_3x4_after_clear", 1'b0, 32'd3, 32'd4, 64'd12), 0, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
